nes_pad_poller: RTL and testbench

//  Console-side initiator for a physical NES controller: drives LATCH and CLK into the pad's
//  4021 shift register, serially samples DATA and presents a parallel, debounced-by-frame,

---
 rtl/nes_pad_poller_pkg.sv | 27 ++
 rtl/nes_pad_poller_sync_2ff.sv | 23 ++
 rtl/nes_pad_poller.sv | 135 +++++++++++++
 tb/tb_nes_pad_poller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pad_poller_pkg.sv
// Shared definitions for the NES pad poller and joypad-side logic: button bit order,
// poller FSM state encodings and default timing constants.
package nes_pad_poller_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int DEF_POLL_CYCLES  = 29830;
    localparam int DEF_LATCH_CYCLES = 21;
    localparam int DEF_HALF_CYCLES  = 11;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LATCH  = 4'd1,
        ST_WAIT   = 4'd2,
        ST_CLK_LO = 4'd3,
        ST_CLK_HI = 4'd4,
        ST_DONE   = 4'd5
    } poll_state_t;

endpackage

// File: rtl/nes_pad_poller_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous GPIO inputs.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nes_pad_poller.sv
// Console-side NES controller poller: drives LATCH/CLK into the pad's 4021, samples DATA
// and publishes an active-high button byte once per completed poll.
module nes_pad_poller
    import nes_pad_poller_pkg::*;
#(
    parameter int POLL_CYCLES  = DEF_POLL_CYCLES,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int HALF_CYCLES  = DEF_HALF_CYCLES
) (
    input  logic        cpu_clk_in,
    input  logic        reset_in,
    input  logic        enable_in,
    input  logic        poll_now_in,
    input  logic        pad_data_in,
    output logic        pad_latch_out,
    output logic        pad_clk_out,
    output logic [7:0]  buttons_out,
    output logic        buttons_valid_out,
    output logic        pad_present_out,
    output logic        busy_out,
    output logic [15:0] debug_out
);

    localparam int IW        = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int PW        = $clog2(PHASE_MAX + 1);

    poll_state_t    state;
    poll_state_t    next_state;
    logic [IW-1:0]  interval_cnt;
    logic [PW-1:0]  phase_cnt;
    logic [3:0]     bit_cnt;
    logic [7:0]     shift;
    logic           bit8;
    logic           data_sync;
    logic           interval_wrap;
    logic           poll_req;
    logic           phase_last;
    logic           sample_now;

    sync_2ff #(.RESET_VALUE(1'b1)) u_data_sync (
        .clk (cpu_clk_in),
        .rst (reset_in),
        .d   (pad_data_in),
        .q   (data_sync)
    );

    assign interval_wrap = enable_in && (interval_cnt == IW'(POLL_CYCLES - 1));
    assign poll_req      = interval_wrap || poll_now_in;

    always_ff @(posedge cpu_clk_in or posedge reset_in) begin
        if (reset_in) begin
            interval_cnt <= '0;
        end else if (!enable_in || interval_wrap) begin
            interval_cnt <= '0;
        end else begin
            interval_cnt <= interval_cnt + IW'(1);
        end
    end

    always_comb begin
        phase_last = 1'b0;
        case (state)
            ST_LATCH:                      phase_last = (phase_cnt == PW'(LATCH_CYCLES - 1));
            ST_WAIT, ST_CLK_LO, ST_CLK_HI: phase_last = (phase_cnt == PW'(HALF_CYCLES - 1));
            default:                       phase_last = 1'b0;
        endcase
    end

    // Samples are taken at the end of a clock-high phase so the synchroniser has settled.
    assign sample_now = phase_last && ((state == ST_WAIT) || (state == ST_CLK_HI));

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (poll_req)   next_state = ST_LATCH;
            ST_LATCH:  if (phase_last) next_state = ST_WAIT;
            ST_WAIT:   if (phase_last) next_state = ST_CLK_LO;
            ST_CLK_LO: if (phase_last) next_state = ST_CLK_HI;
            ST_CLK_HI: if (phase_last) next_state = (bit_cnt == 4'd8) ? ST_DONE : ST_CLK_LO;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_in or posedge reset_in) begin
        if (reset_in) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge cpu_clk_in or posedge reset_in) begin
        if (reset_in) begin
            phase_cnt         <= '0;
            bit_cnt           <= '0;
            shift             <= '0;
            bit8              <= 1'b1;
            buttons_out       <= '0;
            pad_present_out   <= 1'b0;
            buttons_valid_out <= 1'b0;
        end else begin
            if ((next_state != state) || (state == ST_IDLE)) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + PW'(1);
            end

            if (state == ST_IDLE) begin
                bit_cnt <= '0;
            end else if (sample_now) begin
                if (bit_cnt[3]) begin
                    bit8 <= data_sync;
                end else begin
                    shift[bit_cnt[2:0]] <= data_sync;
                end
                bit_cnt <= bit_cnt + 4'd1;
            end

            // Pad DATA is active-low; the published byte and presence flag are active-high.
            buttons_valid_out <= (state == ST_DONE);
            if (state == ST_DONE) begin
                buttons_out     <= ~shift;
                pad_present_out <= ~bit8;
            end
        end
    end

    assign pad_latch_out = (state == ST_LATCH);
    assign pad_clk_out   = (state != ST_CLK_LO);
    assign busy_out      = (state != ST_IDLE);
    assign debug_out     = {state, bit_cnt, shift};

endmodule

// File: tb/tb_nes_pad_poller.sv
// Self-checking bench for nes_pad_poller driving a behavioural 4021 pad model.
module tb_nes_pad_poller;

    localparam int POLL     = 300;
    localparam int LATCH    = 21;
    localparam int HALF     = 11;
    localparam int POLL_LEN = LATCH + HALF + 8 * 2 * HALF + 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        poll_now;
    logic        pad_data;
    logic        pad_latch;
    logic        pad_clk;
    logic [7:0]  buttons;
    logic        valid;
    logic        present;
    logic        busy;
    logic [15:0] debug;

    int checks = 0;
    int passed = 0;

    // Behavioural 4021: parallel load on latch rise, shift on CLK rise, serial-in low.
    logic [7:0] pad_pressed   = 8'h00;
    logic       pad_connected = 1'b1;
    logic [7:0] pad_q         = 8'hFF;

    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) pad_q <= ~pad_pressed;
        else           pad_q <= {1'b0, pad_q[7:1]};
    end

    assign pad_data = pad_connected ? pad_q[0] : 1'b1;

    always #5 clock = ~clock;

    nes_pad_poller #(
        .POLL_CYCLES  (POLL),
        .LATCH_CYCLES (LATCH),
        .HALF_CYCLES  (HALF)
    ) dut (
        .cpu_clk_in        (clock),
        .reset_in          (reset),
        .enable_in         (enable),
        .poll_now_in       (poll_now),
        .pad_data_in       (pad_data),
        .pad_latch_out     (pad_latch),
        .pad_clk_out       (pad_clk),
        .buttons_out       (buttons),
        .buttons_valid_out (valid),
        .pad_present_out   (present),
        .busy_out          (busy),
        .debug_out         (debug)
    );

    // Requests one poll and checks its waveform shape and published result.
    task automatic run_poll(input string name, input logic [7:0] exp_btn, input logic exp_pres,
                            input logic do_change, input logic [7:0] new_pat);
        int   lat = 0, falls = 0, busy_n = 0, valid_n = 0, n = 0;
        logic prev_clk = 1'b1, done = 1'b0, changed = 1'b0;
        logic [7:0] btn_seen = 8'h00;
        @(negedge clock);
        poll_now = 1'b1;
        while (!done && n < 600) begin
            @(negedge clock);
            poll_now = 1'b0;
            n++;
            if (pad_latch) lat++;
            if (prev_clk && !pad_clk) falls++;
            prev_clk = pad_clk;
            if (busy) busy_n++;
            if (do_change && !changed && lat == LATCH && !pad_latch) begin
                pad_pressed = new_pat;
                changed = 1'b1;
            end
            if (valid) begin
                valid_n++;
                done = 1'b1;
                btn_seen = buttons;
            end
        end
        checks++;
        if (!done) $display("[TB] FAIL %s timeout: no valid pulse within %0d cycles", name, n);
        else passed++;
        checks++;
        if (btn_seen !== exp_btn) $display("[TB] FAIL %s buttons: got %h expected %h", name, btn_seen, exp_btn);
        else passed++;
        checks++;
        if (present !== exp_pres) $display("[TB] FAIL %s present: got %b expected %b", name, present, exp_pres);
        else passed++;
        checks++;
        if (busy_n !== POLL_LEN) $display("[TB] FAIL %s busy length: got %0d expected %0d", name, busy_n, POLL_LEN);
        else passed++;
        checks++;
        if (lat !== LATCH) $display("[TB] FAIL %s latch width: got %0d expected %0d", name, lat, LATCH);
        else passed++;
        checks++;
        if (falls !== 8) $display("[TB] FAIL %s clk pulses: got %0d expected 8", name, falls);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (valid) valid_n++;
        end
        checks++;
        if (valid_n !== 1) $display("[TB] FAIL %s valid pulses: got %0d expected 1", name, valid_n);
        else passed++;
        checks++;
        if (buttons !== exp_btn) $display("[TB] FAIL %s hold: got %h expected %h", name, buttons, exp_btn);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; poll_now = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (pad_latch !== 1'b0) $display("[TB] FAIL reset latch: got %b expected 0", pad_latch); else passed++;
        checks++; if (pad_clk !== 1'b1) $display("[TB] FAIL reset clk: got %b expected 1", pad_clk); else passed++;
        checks++; if (buttons !== 8'h00) $display("[TB] FAIL reset buttons: got %h expected 00", buttons); else passed++;
        checks++; if (valid !== 1'b0) $display("[TB] FAIL reset valid: got %b expected 0", valid); else passed++;
        checks++; if (present !== 1'b0) $display("[TB] FAIL reset present: got %b expected 0", present); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset busy: got %b expected 0", busy); else passed++;
        reset = 1'b0;
        repeat (10) @(negedge clock);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL idle busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_a_start();
        pad_pressed = 8'h09; pad_connected = 1'b1;
        run_poll("a_start", 8'h09, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_disconnected();
        pad_connected = 1'b0;
        run_poll("disconnected", 8'h00, 1'b0, 1'b0, 8'h00);
        pad_connected = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            logic [7:0] pat;
            logic       conn;
            pat  = 8'($urandom);
            conn = 1'($urandom_range(0, 3) != 0);
            pad_pressed = pat; pad_connected = conn;
            run_poll($sformatf("random%0d", k), conn ? pat : 8'h00, conn, 1'b0, 8'h00);
        end
        pad_connected = 1'b1;
    endtask

    task automatic test_change_midpoll();
        pad_pressed = 8'h01;
        run_poll("latched_value", 8'h01, 1'b1, 1'b1, 8'h3C);
        run_poll("following_poll", 8'h3C, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_periodic();
        int   starts[$];
        int   valid_n = 0, run = 0;
        logic prev_busy = 1'b0;
        pad_pressed = 8'h80; pad_connected = 1'b1;
        @(negedge clock);
        enable = 1'b1;
        for (int n = 1; n <= 1400; n++) begin
            @(negedge clock);
            if (busy && !prev_busy) starts.push_back(n);
            if (busy) run++;
            else if (prev_busy) begin
                checks++;
                if (run !== POLL_LEN) $display("[TB] FAIL periodic run length: got %0d expected %0d", run, POLL_LEN);
                else passed++;
                run = 0;
            end
            prev_busy = busy;
            if (valid) begin
                valid_n++;
                checks++;
                if (buttons !== 8'h80) $display("[TB] FAIL periodic buttons: got %h expected 80", buttons);
                else passed++;
            end
            if (starts.size() == 3 && n == starts[2] + 50) enable = 1'b0;
        end
        checks++;
        if (starts.size() !== 3) $display("[TB] FAIL periodic poll count: got %0d expected 3", starts.size());
        else passed++;
        for (int k = 0; k < starts.size(); k++) begin
            checks++;
            if (starts[k] !== POLL * (k + 1)) $display("[TB] FAIL periodic start%0d: got %0d expected %0d", k, starts[k], POLL * (k + 1));
            else passed++;
        end
        checks++;
        if (valid_n !== 3) $display("[TB] FAIL periodic valid count: got %0d expected 3", valid_n);
        else passed++;
    endtask

    task automatic test_coincident();
        int   starts[$];
        int   valid_n = 0, run = 0, next_start = POLL;
        logic prev_busy = 1'b0;
        pad_pressed = 8'h80;
        @(negedge clock);
        enable = 1'b1;
        for (int n = 1; n <= 1500; n++) begin
            @(negedge clock);
            poll_now = 1'b0;
            if (busy && !prev_busy) begin
                starts.push_back(n);
                next_start = n + POLL;
            end
            if (busy) run++;
            else if (prev_busy) begin
                checks++;
                if (run !== POLL_LEN) $display("[TB] FAIL coincident run length: got %0d expected %0d", run, POLL_LEN);
                else passed++;
                run = 0;
            end
            prev_busy = busy;
            if (valid) valid_n++;
            if (n == 1250) enable = 1'b0;
            if (n < 1250 && (n == next_start - 1 || (starts.size() > 0 && n == starts[$] + 50)))
                poll_now = 1'b1;
        end
        checks++;
        if (starts.size() !== 4) $display("[TB] FAIL coincident poll count: got %0d expected 4", starts.size());
        else passed++;
        for (int k = 0; k < starts.size(); k++) begin
            checks++;
            if (starts[k] !== POLL * (k + 1)) $display("[TB] FAIL coincident start%0d: got %0d expected %0d", k, starts[k], POLL * (k + 1));
            else passed++;
        end
        checks++;
        if (valid_n !== 4) $display("[TB] FAIL coincident valid count: got %0d expected 4", valid_n);
        else passed++;
    endtask

    task automatic test_reset_midpoll();
        int   falls = 0, n = 0;
        logic prev_clk = 1'b1;
        checks++;
        if (buttons !== 8'h80) $display("[TB] FAIL pre-reset buttons: got %h expected 80", buttons);
        else passed++;
        pad_pressed = 8'hF0;
        @(negedge clock);
        poll_now = 1'b1;
        while (falls < 5 && n < 600) begin
            @(negedge clock);
            poll_now = 1'b0;
            n++;
            if (prev_clk && !pad_clk) falls++;
            prev_clk = pad_clk;
        end
        checks++;
        if (falls < 5) $display("[TB] FAIL midpoll clk pulses: got %0d expected 5", falls);
        else passed++;
        reset = 1'b1;
        #1;
        checks++; if (pad_latch !== 1'b0) $display("[TB] FAIL midreset latch: got %b expected 0", pad_latch); else passed++;
        checks++; if (pad_clk !== 1'b1) $display("[TB] FAIL midreset clk: got %b expected 1", pad_clk); else passed++;
        checks++; if (buttons !== 8'h00) $display("[TB] FAIL midreset buttons: got %h expected 00", buttons); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL midreset busy: got %b expected 0", busy); else passed++;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL post-reset busy: got %b expected 0", busy); else passed++;
        run_poll("after_reset", 8'hF0, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; poll_now = 1'b0;
        test_reset();
        test_a_start();
        test_disconnected();
        test_random();
        test_change_midpoll();
        test_periodic();
        test_coincident();
        test_reset_midpoll();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
